// File: rtl/convolver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : convolver_pkg
// Description : Shared constants and width helpers for the convolver datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package convolver_pkg;

    localparam int c_default_kernel_size = 5;
    localparam int c_default_data_width  = 16;
    localparam int c_default_frac_bits   = 8;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int f_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a sum of 'count' full-width products of 'data_width' operands
    function automatic int f_sum_width(input int data_width, input int count);
        return 2 * data_width + f_clog2(count);
    endfunction

    // Number of operands present at a given level of a pairwise reduction
    function automatic int f_level_count(input int count, input int level);
        int n;
        n = count;
        for (int l = 0; l < level; l++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree
// Description : Registered pairwise signed adder tree with a matching valid chain.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree
    import convolver_pkg::*;
#(
    parameter int COUNT = 5,
    parameter int WIDTH = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [COUNT*WIDTH-1:0]             i_data,
    input  logic                               i_valid,
    output logic [WIDTH+f_clog2(COUNT)-1:0]    o_sum,
    output logic                               o_valid
);

    localparam int c_levels = f_clog2(COUNT);

    // Each level grows by one bit, so no level can overflow.
    for (genvar l = 0; l <= c_levels; l++) begin : g_level
        localparam int c_n = f_level_count(COUNT, l);
        localparam int c_w = WIDTH + l;

        logic [c_n*c_w-1:0] w_data;
        logic               w_valid;

        if (l == 0) begin : g_input
            assign w_data  = i_data;
            assign w_valid = i_valid;
        end else begin : g_stage
            localparam int c_np = f_level_count(COUNT, l - 1);
            localparam int c_wp = c_w - 1;

            logic [c_np*c_wp-1:0] w_prev;
            logic [c_n*c_w-1:0]   w_sum;
            logic [c_n*c_w-1:0]   r_data;
            logic                 r_valid;

            assign w_prev = g_level[l-1].w_data;

            for (genvar j = 0; j < c_n; j++) begin : g_node
                logic signed [c_w-1:0] w_a;
                logic signed [c_w-1:0] w_b;

                assign w_a = c_w'($signed(w_prev[2*j*c_wp +: c_wp]));
                if (2 * j + 1 < c_np) begin : g_pair
                    assign w_b = c_w'($signed(w_prev[(2*j+1)*c_wp +: c_wp]));
                end else begin : g_pass
                    assign w_b = '0;
                end
                assign w_sum[j*c_w +: c_w] = w_a + w_b;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_data  <= w_sum;
                    r_valid <= g_level[l-1].w_valid;
                end
            end

            assign w_data  = r_data;
            assign w_valid = r_valid;
        end
    end

    assign o_sum   = g_level[c_levels].w_data;
    assign o_valid = g_level[c_levels].w_valid;

endmodule
`default_nettype wire

// File: rtl/window_mac.sv
`default_nettype none
// ============================================================================
// Module      : window_mac
// Description : Pipelined weighted dot product of one tap row, rounded and
//               saturated back to the sample width.
// Revision    : 1.0 - initial release
// ============================================================================
module window_mac
    import convolver_pkg::*;
#(
    parameter int KERNEL_SIZE = c_default_kernel_size,
    parameter int DATA_WIDTH  = c_default_data_width,
    parameter int FRAC_BITS   = c_default_frac_bits
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] window_in,
    input  logic                              window_valid,
    input  logic [DATA_WIDTH-1:0]             weight_in,
    input  logic                              weight_load,
    output logic                              weights_ready,
    output logic [DATA_WIDTH-1:0]             result,
    output logic                              result_valid
);

    localparam int c_prod_w = 2 * DATA_WIDTH;
    localparam int c_sum_w  = f_sum_width(DATA_WIDTH, KERNEL_SIZE);
    localparam int c_rnd_w  = c_sum_w + 1;
    localparam int c_cnt_w  = f_clog2(KERNEL_SIZE + 1);

    localparam logic [c_cnt_w-1:0]        c_full     = c_cnt_w'(KERNEL_SIZE);
    localparam logic signed [c_rnd_w-1:0] c_half     = c_rnd_w'(1) << (FRAC_BITS - 1);
    localparam logic signed [c_rnd_w-1:0] c_sat_max  = (c_rnd_w'(1) << (DATA_WIDTH - 1)) - c_rnd_w'(1);
    localparam logic signed [c_rnd_w-1:0] c_sat_min  = -(c_rnd_w'(1) << (DATA_WIDTH - 1));

    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] r_weights;
    logic [c_cnt_w-1:0]                     r_count;
    logic [c_cnt_w-1:0]                     w_count_next;
    logic                                   r_ready;

    logic [KERNEL_SIZE*c_prod_w-1:0]        w_prod;
    logic [KERNEL_SIZE*c_prod_w-1:0]        r_prod;
    logic                                   r_prod_valid;

    logic [c_sum_w-1:0]                     w_sum;
    logic                                   w_sum_valid;
    logic signed [c_rnd_w-1:0]              w_rounded;
    logic signed [c_rnd_w-1:0]              w_shifted;
    logic [DATA_WIDTH-1:0]                  w_sat;

    logic [DATA_WIDTH-1:0]                  r_result;
    logic                                   r_result_valid;

    // A load on a full bank starts a fresh set rather than saturating silently.
    assign w_count_next = (r_count == c_full) ? c_cnt_w'(1) : r_count + c_cnt_w'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_weights <= '0;
            r_count   <= '0;
            r_ready   <= 1'b0;
        end else if (weight_load) begin
            r_weights[0] <= weight_in;
            for (int i = 1; i < KERNEL_SIZE; i++) begin
                r_weights[i] <= r_weights[i-1];
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next == c_full);
        end
    end

    for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_tap
        assign w_prod[i*c_prod_w +: c_prod_w] =
            c_prod_w'($signed(window_in[i*DATA_WIDTH +: DATA_WIDTH])) *
            c_prod_w'($signed(r_weights[i]));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
        end else begin
            r_prod       <= w_prod;
            r_prod_valid <= window_valid && r_ready;
        end
    end

    adder_tree #(
        .COUNT (KERNEL_SIZE),
        .WIDTH (c_prod_w)
    ) u_adder_tree (
        .clock   (clock),
        .reset   (reset),
        .i_data  (r_prod),
        .i_valid (r_prod_valid),
        .o_sum   (w_sum),
        .o_valid (w_sum_valid)
    );

    // Round half up, then clamp to the representable sample range.
    assign w_rounded = c_rnd_w'($signed(w_sum)) + c_half;
    assign w_shifted = w_rounded >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > c_sat_max) begin
            w_sat = c_sat_max[DATA_WIDTH-1:0];
        end else if (w_shifted < c_sat_min) begin
            w_sat = c_sat_min[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_sum_valid;
            if (w_sum_valid) begin
                r_result <= w_sat;
            end
        end
    end

    assign weights_ready = r_ready;
    assign result        = r_result;
    assign result_valid  = r_result_valid;

endmodule
`default_nettype wire
